// File: rtl/mem_pkg.sv
// Shared definitions for the RV64 memory-access stage: memop encodings,
// FSM state type, trap causes and small size-decoding helpers.
package mem_pkg;

    localparam int XLEN = 64;

    // funct3 encodings for loads/stores (3'b111 behaves like MEM_D)
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    localparam logic [XLEN-1:0] CAUSE_LD_MISALIGN = 64'd4;
    localparam logic [XLEN-1:0] CAUSE_ST_MISALIGN = 64'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] offset_mask(input logic [1:0] size_code);
        case (size_code)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // Byte enables for an access of the given size starting at lane 0
    function automatic logic [7:0] byte_mask(input logic [1:0] size_code);
        case (size_code)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// load_store_align: combinational lane shifting, byte-enable generation,
// load extension and misalignment detection for one access.
// MEM_MISALIGN_EXCEPT_EN defined: misaligned addresses are flagged.
// Undefined: the low address bits are force-aligned and never flagged.
module load_store_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] i_addr,
    input  logic [2:0]      i_memop,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_load_data,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_wdata,
    output logic [7:0]      o_wmask,
    output logic [XLEN-1:0] o_load_result,
    output logic            o_misaligned
);

    logic [2:0]      w_off_mask;
    logic [2:0]      w_lane;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_rdata_shifted;

    assign w_off_mask = offset_mask(i_memop[1:0]);

`ifdef MEM_MISALIGN_EXCEPT_EN
    assign o_misaligned = |(i_addr[2:0] & w_off_mask);
    assign w_lane       = i_addr[2:0];
`else
    assign o_misaligned = 1'b0;
    assign w_lane       = i_addr[2:0] & ~w_off_mask;
`endif

    assign w_shamt         = {w_lane, 3'b000};
    assign o_bus_addr      = {i_addr[XLEN-1:3], 3'b000};
    assign o_wdata         = i_store_data << w_shamt;
    assign o_wmask         = byte_mask(i_memop[1:0]) << w_lane;
    assign w_rdata_shifted = i_load_data >> w_shamt;

    // Truncate the lane-shifted read data to the access size, then extend
    always_comb begin
        // NOTE: every path assigns the output, so no latch is inferred.
        o_load_result = w_rdata_shifted;
        case (i_memop)
            MEM_B:   o_load_result = {{56{w_rdata_shifted[7]}},  w_rdata_shifted[7:0]};
            MEM_H:   o_load_result = {{48{w_rdata_shifted[15]}}, w_rdata_shifted[15:0]};
            MEM_W:   o_load_result = {{32{w_rdata_shifted[31]}}, w_rdata_shifted[31:0]};
            MEM_BU:  o_load_result = {56'd0, w_rdata_shifted[7:0]};
            MEM_HU:  o_load_result = {48'd0, w_rdata_shifted[15:0]};
            MEM_WU:  o_load_result = {32'd0, w_rdata_shifted[31:0]};
            default: o_load_result = w_rdata_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the RV64 pipeline. Issues one data-bus
// transaction per load/store over a req/ack handshake, stalls the pipe while
// it is outstanding, and returns extended load data in dmem_mem.
// MEM_MISALIGN_EXCEPT_EN selects misaligned-access exceptions; without it
// addresses are force-aligned and except_* are tied to 0.
module mem_access_stage
    import mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_mem,
    input  logic            re_mem,
    input  logic            we_mem_mem,
    input  logic [2:0]      memop_mem,
    input  logic [XLEN-1:0] alu_res_mem,
    input  logic [XLEN-1:0] rs2_data_mem,
    input  logic            flush,
    input  logic            stall_ext,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [XLEN-1:0] dbus_wdata,
    output logic [7:0]      dbus_wmask,
    input  logic            dbus_ack,
    input  logic [XLEN-1:0] dbus_rdata,
    output logic [XLEN-1:0] dmem_mem,
    output logic [XLEN-1:0] rw_wdata,
    output logic            stall_mem,
    output logic            except_happen_mem,
    output logic [XLEN-1:0] except_cause_mem,
    output logic [XLEN-1:0] except_tval_mem
);

    state_e          r_state;
    state_e          w_next_state;
    logic            r_drop;
    logic [XLEN-1:0] r_dmem;

    // Transaction captured at issue so the bus stays stable while waiting
    logic            r_we;
    logic [2:0]      r_memop;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_rs2;

    logic            w_acc;
    logic            w_in_wait;
    logic            w_issue;
    logic            w_drive;
    logic            w_sel_we;
    logic [2:0]      w_sel_memop;
    logic [XLEN-1:0] w_sel_addr;
    logic [XLEN-1:0] w_sel_rs2;
    logic [XLEN-1:0] w_bus_addr;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_wmask;
    logic [XLEN-1:0] w_load_result;
    logic            w_misaligned;

    assign w_acc     = valid_mem & (re_mem | we_mem_mem) & ~flush;
    assign w_in_wait = (r_state == ST_WAIT);

    // In WAIT the aligner sees the captured transaction, otherwise live inputs
    assign w_sel_we    = w_in_wait ? r_we    : we_mem_mem;
    assign w_sel_memop = w_in_wait ? r_memop : memop_mem;
    assign w_sel_addr  = w_in_wait ? r_addr  : alu_res_mem;
    assign w_sel_rs2   = w_in_wait ? r_rs2   : rs2_data_mem;

    load_store_align u_align (
        .i_addr        (w_sel_addr),
        .i_memop       (w_sel_memop),
        .i_store_data  (w_sel_rs2),
        .i_load_data   (dbus_rdata),
        .o_bus_addr    (w_bus_addr),
        .o_wdata       (w_wdata),
        .o_wmask       (w_wmask),
        .o_load_result (w_load_result),
        .o_misaligned  (w_misaligned)
    );

    // Outputs are forced quiet while rst is high so reset leaves every output 0
    assign w_issue = ~rst & (r_state == ST_IDLE) & w_acc & ~w_misaligned;
    assign w_drive = w_issue | (w_in_wait & ~rst);

    assign dbus_req   = w_drive;
    assign stall_mem  = w_drive;
    assign dbus_we    = w_drive & w_sel_we;
    assign dbus_addr  = w_drive ? w_bus_addr : '0;
    assign dbus_wdata = w_drive ? w_wdata    : '0;
    assign dbus_wmask = w_drive ? w_wmask    : '0;
    assign rw_wdata   = dbus_wdata;
    assign dmem_mem   = r_dmem;

`ifdef MEM_MISALIGN_EXCEPT_EN
    logic w_except;
    assign w_except          = ~rst & w_acc & w_misaligned;
    assign except_happen_mem = w_except;
    assign except_cause_mem  = w_except ? (we_mem_mem ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN) : '0;
    assign except_tval_mem   = w_except ? alu_res_mem : '0;
`else
    assign except_happen_mem = 1'b0;
    assign except_cause_mem  = '0;
    assign except_tval_mem   = '0;
`endif

    // Next-state logic: a started transaction always runs to its ack
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_next_state = ST_WAIT;
            ST_WAIT: if (dbus_ack) w_next_state = (r_drop | flush) ? ST_IDLE : ST_DONE;
            ST_DONE: if (flush | ~stall_ext) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, drop flag and load-result register
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
            r_dmem  <= '0;
        end else begin
            r_state <= w_next_state;
            r_drop  <= w_in_wait & ~dbus_ack & (r_drop | flush);
            if (w_in_wait & dbus_ack & ~r_drop & ~flush & ~r_we)
                r_dmem <= w_load_result;
        end
    end

    // Capture the transaction on issue
    always_ff @(posedge clk) begin
        // NOTE: no reset here: these are only read in WAIT, which is always
        // entered through a capture on this same edge.
        if (w_issue) begin
            r_we    <= we_mem_mem;
            r_memop <= memop_mem;
            r_addr  <= alu_res_mem;
            r_rs2   <= rs2_data_mem;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected bus
// requests and completions; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_mem, re_mem, we_mem_mem, flush, stall_ext;
    logic [2:0]  memop_mem;
    logic [63:0] alu_res_mem, rs2_data_mem;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [7:0]  dbus_wmask;
    logic [63:0] dmem_mem, rw_wdata;
    logic        stall_mem, except_happen_mem;
    logic [63:0] except_cause_mem, except_tval_mem;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .valid_mem(valid_mem), .re_mem(re_mem),
        .we_mem_mem(we_mem_mem), .memop_mem(memop_mem), .alu_res_mem(alu_res_mem),
        .rs2_data_mem(rs2_data_mem), .flush(flush), .stall_ext(stall_ext),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wmask(dbus_wmask), .dbus_ack(dbus_ack),
        .dbus_rdata(dbus_rdata), .dmem_mem(dmem_mem), .rw_wdata(rw_wdata),
        .stall_mem(stall_mem), .except_happen_mem(except_happen_mem),
        .except_cause_mem(except_cause_mem), .except_tval_mem(except_tval_mem)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic        chk_dmem;
        logic [63:0] dmem;
    } done_t;

    req_t  q_req[$];
    done_t q_done[$];

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_dmem = 64'd0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.wmask = wmask;
        q_req.push_back(r);
    endtask

    task automatic push_done(input logic chk, input logic [63:0] dmem);
        done_t d;
        d.chk_dmem = chk; d.dmem = dmem;
        q_done.push_back(d);
    endtask

    // Monitor: compares bus requests, their stability, and each completion
    logic m_busy = 1'b0;
    logic m_done_pend = 1'b0;
    int   m_age = 0;
    req_t m_cur;
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done_pend = 1'b0;
            m_age = 0;
        end else begin
            if (m_done_pend) begin
                m_done_pend = 1'b0;
                if (q_done.size() == 0) begin
                    check("done_unexpected", 192'(q_done.size()), 192'd1);
                end else begin
                    done_t d;
                    d = q_done.pop_front();
                    check("done_stall_req", {stall_mem, dbus_req}, 2'b00);
                    if (d.chk_dmem) check("done_dmem", dmem_mem, d.dmem);
                end
            end
            if (dbus_req) begin
                if (!m_busy) begin
                    if (q_req.size() == 0) begin
                        check("req_unexpected", dbus_req, 1'b0);
                    end else begin
                        m_cur = q_req.pop_front();
                        check("req_fields", {dbus_we, dbus_addr, dbus_wdata, dbus_wmask},
                              {m_cur.we, m_cur.addr, m_cur.wdata, m_cur.wmask});
                        check("rw_wdata", rw_wdata, m_cur.wdata);
                        m_busy = 1'b1;
                        m_age  = 0;
                    end
                end else begin
                    check("req_hold", {dbus_we, dbus_addr, dbus_wdata, dbus_wmask},
                          {m_cur.we, m_cur.addr, m_cur.wdata, m_cur.wmask});
                end
                if (m_busy && dbus_ack && m_age > 0) begin
                    m_busy = 1'b0;
                    m_done_pend = 1'b1;
                end
                m_age++;
            end
        end
    end

    task automatic idle_inputs();
        valid_mem = 0; re_mem = 0; we_mem_mem = 0; memop_mem = 3'b000;
        alu_res_mem = '0; rs2_data_mem = '0; flush = 0; stall_ext = 0;
        dbus_ack = 0; dbus_rdata = '0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, {dbus_req, dbus_we, stall_mem, except_happen_mem, dbus_wmask}, '0);
        check({name, "_bus"},  {dbus_addr, dbus_wdata, rw_wdata}, '0);
        check({name, "_data"}, {dmem_mem, except_cause_mem, except_tval_mem}, '0);
    endtask

    // One access: ack on cycle ack_at (and optionally cycle 0), optional flush
    task automatic do_access(input string name, input logic st, input logic [2:0] op,
                             input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] rdata,
                             input int ack_at, input bit ack0, input int flush_at, input int n_cyc,
                             input int exp_stall, input logic exp_exc, input logic [63:0] exp_cause);
        int stalls = 0;
        valid_mem = 1; re_mem = ~st; we_mem_mem = st; memop_mem = op;
        alu_res_mem = addr; rs2_data_mem = rs2; dbus_rdata = rdata;
        for (int c = 0; c < n_cyc; c++) begin
            dbus_ack = (c == ack_at) || (ack0 && c == 0);
            flush    = (c == flush_at);
            if (flush_at >= 0 && c > flush_at) valid_mem = 0;
            @(negedge clk);
            stalls += int'(stall_mem);
            if (c == 0) begin
                check({name, "_exc"}, {except_happen_mem, except_cause_mem}, {exp_exc, exp_cause});
                check({name, "_tval"}, except_tval_mem, exp_exc ? addr : 64'd0);
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        check({name, "_stall_cycles"}, 192'(stalls), 192'(exp_stall));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        valid_mem = 1; re_mem = 1; alu_res_mem = 64'h1000;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        idle_inputs();
        rst = 0;

        // LB, ack on the 4th cycle: byte 0x80 sign-extended
        push_req(1'b0, 64'h1000, 64'h0, 8'h08);
        exp_dmem = 64'hFFFF_FFFF_FFFF_FF80;
        push_done(1'b1, exp_dmem);
        do_access("lb", 1'b0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 3, 1'b0, -1, 5, 4, 1'b0, 64'd0);

        // SH to upper lanes; ack in the issue cycle is ignored
        push_req(1'b1, 64'h1000, 64'hABCD_0000_0000_0000, 8'hC0);
        push_done(1'b0, 64'd0);
        do_access("sh", 1'b1, 3'b001, 64'h1006, 64'h0000_0000_0000_ABCD, 64'h0, 2, 1'b1, -1, 4, 3, 1'b0, 64'd0);

`ifdef MEM_MISALIGN_EXCEPT_EN
        do_access("lw_mis", 1'b0, 3'b010, 64'h1002, 64'h0, 64'h0, -1, 1'b0, -1, 2, 0, 1'b1, 64'd4);
        do_access("sd_mis", 1'b1, 3'b011, 64'h1004, 64'h0123_4567_89AB_CDEF, 64'h0, -1, 1'b0, -1, 2, 0, 1'b1, 64'd6);
`else
        push_req(1'b0, 64'h1000, 64'h0, 8'h0F);
        exp_dmem = 64'hFFFF_FFFF_8899_AABB;
        push_done(1'b1, exp_dmem);
        do_access("lw_align", 1'b0, 3'b010, 64'h1002, 64'h0, 64'h1122_3344_8899_AABB, 1, 1'b0, -1, 3, 2, 1'b0, 64'd0);
        push_req(1'b1, 64'h1000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        push_done(1'b0, 64'd0);
        do_access("sd_align", 1'b1, 3'b011, 64'h1004, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 1'b0, -1, 3, 2, 1'b0, 64'd0);
`endif

        // LD flushed while waiting: data discarded, dmem unchanged
        push_req(1'b0, 64'h2000, 64'h0, 8'hFF);
        push_done(1'b1, exp_dmem);
        do_access("ld_flush", 1'b0, 3'b011, 64'h2000, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 3, 1'b0, 1, 5, 4, 1'b0, 64'd0);

        // LHU, then DONE held by stall_ext, then re-issue, then reset in WAIT
        valid_mem = 1; re_mem = 1; memop_mem = 3'b101; alu_res_mem = 64'h3002;
        dbus_rdata = 64'h0000_0000_9876_0000;
        push_req(1'b0, 64'h3000, 64'h0, 8'h0C);
        push_done(1'b1, 64'h0000_0000_0000_9876);
        @(negedge clk);
        @(posedge clk); #1;
        dbus_ack = 1;
        @(negedge clk);
        @(posedge clk); #1;
        dbus_ack = 0; stall_ext = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_hold", {dbus_req, stall_mem, dmem_mem}, {2'b00, 64'h0000_0000_0000_9876});
            @(posedge clk); #1;
        end
        stall_ext = 0;
        push_req(1'b0, 64'h3000, 64'h0, 8'h0C);
        @(negedge clk);
        check("done_last_cycle", {dbus_req, stall_mem}, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("reissue_from_idle", {dbus_req, stall_mem}, 2'b11);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("rst_in_wait_req", {dbus_req, stall_mem}, 2'b00);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check_all_zero("after_rst");
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_all_zero("post_rst");

        repeat (3) @(posedge clk);
        #1;
        check("q_req_drained", 192'(q_req.size()), 192'd0);
        check("q_done_drained", 192'(q_done.size()), 192'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
